// File: rtl/ctrl_unit_if.sv
// Operand-fetch control bundle between the d6809 microsequencer and its datapath.
// No latency of its own; it only groups the signals.
// No backpressure: the datapath acts on every strobe in the cycle it appears.
interface ctrl_unit_if;
  // Datapath register views (only IR[7:0] is decoded by the sequencer)
  logic [15:0] IR;
  logic [15:0] PC;
  logic [15:0] AR;
  logic [7:0]  T;
  logic [7:0]  DP;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] X;
  logic [15:0] Y;
  // Sequencer controls
  logic [15:0] fetch;
  logic        pc_inc;
  logic [3:0]  mem_read;

  modport master (
    input  IR, PC, AR, T, DP, A, B, X, Y,
    output fetch, pc_inc, mem_read
  );

  modport slave (
    output IR, PC, AR, T, DP, A, B, X, Y,
    input  fetch, pc_inc, mem_read
  );
endinterface

// File: rtl/ctrl_unit.sv
// Microsequencer: decodes IR and state into bus-read source, register load strobes and PC increment.
// Outputs are combinational from state; every read cycle is followed by one idle gap cycle.
// No backpressure: the datapath latches the data bus on every posedge where a fetch bit is set.
module ctrl_unit (
  input  logic      clk,
  input  logic      reset,
  ctrl_unit_if.master bus
);
  localparam logic [3:0] MEMREAD_NONE   = 4'd0;
  localparam logic [3:0] MEMREAD_PC     = 4'd1;
  localparam logic [3:0] MEMREAD_AR     = 4'd2;
  localparam logic [3:0] MEMREAD_DP_ARL = 4'd3;

  localparam logic [3:0] FETCH_IR  = 4'd0;
  localparam logic [3:0] FETCH_ARL = 4'd1;
  localparam logic [3:0] FETCH_ARH = 4'd2;
  localparam logic [3:0] FETCH_A   = 4'd4;
  localparam logic [3:0] FETCH_B   = 4'd5;
  localparam logic [3:0] FETCH_XL  = 4'd6;
  localparam logic [3:0] FETCH_XH  = 4'd7;
  localparam logic [3:0] FETCH_YL  = 4'd8;
  localparam logic [3:0] FETCH_YH  = 4'd9;

  typedef enum logic [3:0] {
    S_IDLE, S_FOP, S_DEC, S_RD1, S_GAP1, S_RD2, S_GAP2, S_RD3, S_GAP3
  } state_t;

  typedef enum logic [2:0] {OP_NONE, OP_IMM8, OP_IMM16, OP_DIR, OP_EXT} op_t;

  state_t      state, state_nxt;
  logic        page2, page2_nxt;
  logic [7:0]  opcode;
  op_t         op;
  logic [3:0]  dst_hi, dst_lo;  // dst_lo is the only destination for 8-bit loads
  logic [1:0]  nreads;

  // Register views the sequencer does not need; the datapath owns them.
  logic unused_bus;
  assign unused_bus = ^{bus.IR[15:8], bus.PC, bus.AR, bus.T, bus.DP,
                        bus.A, bus.B, bus.X, bus.Y};

  assign opcode = bus.IR[7:0];

  // Opcode classification: addressing mode, destination registers and read count.
  always_comb begin
    op     = OP_NONE;
    dst_hi = FETCH_A;
    dst_lo = FETCH_A;
    if (page2) begin
      // Only LDY immediate exists on page 2; anything else falls through as NOP.
      if (opcode == 8'h8E) begin
        op = OP_IMM16; dst_hi = FETCH_YH; dst_lo = FETCH_YL;
      end
    end else begin
      case (opcode)
        8'h86: begin op = OP_IMM8;  dst_lo = FETCH_A; end
        8'hC6: begin op = OP_IMM8;  dst_lo = FETCH_B; end
        8'hCC: begin op = OP_IMM16; dst_hi = FETCH_A;  dst_lo = FETCH_B;  end
        8'h8E: begin op = OP_IMM16; dst_hi = FETCH_XH; dst_lo = FETCH_XL; end
        8'h96: begin op = OP_DIR;   dst_lo = FETCH_A; end
        8'hD6: begin op = OP_DIR;   dst_lo = FETCH_B; end
        8'hB6: begin op = OP_EXT;   dst_lo = FETCH_A; end
        8'hF6: begin op = OP_EXT;   dst_lo = FETCH_B; end
        default: op = OP_NONE;
      endcase
    end
    case (op)
      OP_IMM8:  nreads = 2'd1;
      OP_IMM16: nreads = 2'd2;
      OP_DIR:   nreads = 2'd2;
      OP_EXT:   nreads = 2'd3;
      default:  nreads = 2'd0;
    endcase
  end

  // State and page-2 prefix flag; reset clears both without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      page2 <= 1'b0;
    end else begin
      state <= state_nxt;
      page2 <= page2_nxt;
    end
  end

  // Next state and read controls; gap states leave every output at its default.
  always_comb begin
    state_nxt    = state;
    page2_nxt    = page2;
    bus.mem_read = MEMREAD_NONE;
    bus.fetch    = 16'h0000;
    bus.pc_inc   = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FOP;
      S_FOP: begin
        bus.mem_read        = MEMREAD_PC;
        bus.fetch[FETCH_IR] = 1'b1;
        bus.pc_inc          = 1'b1;
        state_nxt           = S_DEC;
      end
      S_DEC: begin
        if (opcode == 8'h10 && !page2) begin
          page2_nxt = 1'b1;
          state_nxt = S_FOP;
        end else if (nreads == 2'd0) begin
          page2_nxt = 1'b0;
          state_nxt = S_FOP;
        end else begin
          state_nxt = S_RD1;
        end
      end
      S_RD1: begin
        bus.mem_read = MEMREAD_PC;
        bus.pc_inc   = 1'b1;
        case (op)
          OP_IMM8:  bus.fetch[dst_lo]    = 1'b1;
          OP_IMM16: bus.fetch[dst_hi]    = 1'b1;
          OP_DIR:   bus.fetch[FETCH_ARL] = 1'b1;
          OP_EXT:   bus.fetch[FETCH_ARH] = 1'b1;
          default:  bus.fetch            = 16'h0000;
        endcase
        state_nxt = S_GAP1;
      end
      S_GAP1: begin
        if (nreads == 2'd1) begin
          page2_nxt = 1'b0;
          state_nxt = S_FOP;
        end else begin
          state_nxt = S_RD2;
        end
      end
      S_RD2: begin
        case (op)
          OP_IMM16: begin
            bus.mem_read = MEMREAD_PC; bus.pc_inc = 1'b1; bus.fetch[dst_lo] = 1'b1;
          end
          OP_DIR: begin
            bus.mem_read = MEMREAD_DP_ARL; bus.fetch[dst_lo] = 1'b1;
          end
          OP_EXT: begin
            bus.mem_read = MEMREAD_PC; bus.pc_inc = 1'b1; bus.fetch[FETCH_ARL] = 1'b1;
          end
          default: bus.mem_read = MEMREAD_NONE;
        endcase
        state_nxt = S_GAP2;
      end
      S_GAP2: begin
        if (nreads == 2'd2) begin
          page2_nxt = 1'b0;
          state_nxt = S_FOP;
        end else begin
          state_nxt = S_RD3;
        end
      end
      S_RD3: begin
        bus.mem_read      = MEMREAD_AR;
        bus.fetch[dst_lo] = 1'b1;
        state_nxt         = S_GAP3;
      end
      S_GAP3: begin
        page2_nxt = 1'b0;
        state_nxt = S_FOP;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ctrl_unit.sv
// Bench for ctrl_unit: a small datapath and memory model execute short programs.
// Expected mem_read per cycle is queued per program and drained against the DUT.
// Final register values and the reset behaviour are checked against hand-derived constants.
module tb_ctrl_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ctrl_unit_if bus_if ();

  ctrl_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.master)
  );

  // Datapath model
  logic [7:0]  mem [0:65535];
  logic [15:0] ir, pc, ar, x, y;
  logic [7:0]  a, b, dp;
  logic [7:0]  dp_init = 8'h00;
  logic [7:0]  dbus;

  assign bus_if.IR = ir;
  assign bus_if.PC = pc;
  assign bus_if.AR = ar;
  assign bus_if.T  = 8'h00;
  assign bus_if.DP = dp;
  assign bus_if.A  = a;
  assign bus_if.B  = b;
  assign bus_if.X  = x;
  assign bus_if.Y  = y;

  // Data bus driven from memory by the selected read source.
  always_comb begin
    dbus = 8'h00;
    case (bus_if.mem_read)
      4'd1: dbus = mem[pc];
      4'd2: dbus = mem[ar];
      4'd3: dbus = mem[{dp, ar[7:0]}];
      default: dbus = 8'h00;
    endcase
  end

  // Register file: latch the bus on each fetch strobe, bump PC on pc_inc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir <= 16'h0; pc <= 16'h0; ar <= 16'h0; x <= 16'h0; y <= 16'h0;
      a <= 8'h0; b <= 8'h0; dp <= dp_init;
    end else begin
      if (bus_if.fetch[0]) ir <= {8'h00, dbus};
      if (bus_if.fetch[1]) ar[7:0] <= dbus;
      if (bus_if.fetch[2]) ar[15:8] <= dbus;
      if (bus_if.fetch[4]) a <= dbus;
      if (bus_if.fetch[5]) b <= dbus;
      if (bus_if.fetch[6]) x[7:0] <= dbus;
      if (bus_if.fetch[7]) x[15:8] <= dbus;
      if (bus_if.fetch[8]) y[7:0] <= dbus;
      if (bus_if.fetch[9]) y[15:8] <= dbus;
      if (bus_if.pc_inc) pc <= pc + 16'd1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Queue one expected mem_read per cycle: N=NONE P=PC R=AR D=DP_ARL.
  task automatic push_trace(input string s);
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "P": exp_q.push_back(4'd1);
        "R": exp_q.push_back(4'd2);
        "D": exp_q.push_back(4'd3);
        default: exp_q.push_back(4'd0);
      endcase
    end
  endtask

  task automatic drain();
    logic [3:0] e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check("mem_read", {28'h0, bus_if.mem_read}, {28'h0, e});
      check("fetch_onehot", {31'h0, $onehot0(bus_if.fetch)}, 32'd1);
      check("pc_inc_only_pc", {31'h0, bus_if.pc_inc && bus_if.mem_read != 4'd1}, 32'd0);
    end
  endtask

  // Hold reset, fill the low program area with NOPs, and load the program bytes.
  task automatic load(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                      input logic [7:0] p3, input logic [7:0] p4, input logic [7:0] p5,
                      input logic [7:0] p6);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h12;
    mem[0] = p0; mem[1] = p1; mem[2] = p2; mem[3] = p3;
    mem[4] = p4; mem[5] = p5; mem[6] = p6;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    #12;
    check("rst_mem_read", {28'h0, bus_if.mem_read}, 32'd0);
    check("rst_fetch", {16'h0, bus_if.fetch}, 32'd0);
    check("rst_pc_inc", {31'h0, bus_if.pc_inc}, 32'd0);

    // LDA immediate
    load(8'h86, 8'h42, 8'h12, 8'h12, 8'h12, 8'h12, 8'h12);
    release_reset();
    push_trace("NPNPNP"); drain();
    check("lda_imm_a", {24'h0, a}, 32'h42);
    check("lda_imm_pc", {16'h0, pc}, 32'h2);

    // LDD immediate
    load(8'hCC, 8'h12, 8'h34, 8'h12, 8'h12, 8'h12, 8'h12);
    release_reset();
    push_trace("NPNPNPNP"); drain();
    check("ldd_a", {24'h0, a}, 32'h12);
    check("ldd_b", {24'h0, b}, 32'h34);
    check("ldd_pc", {16'h0, pc}, 32'h3);

    // LDX immediate
    load(8'h8E, 8'h56, 8'h78, 8'h12, 8'h12, 8'h12, 8'h12);
    release_reset();
    push_trace("NPNPNPNP"); drain();
    check("ldx_x", {16'h0, x}, 32'h5678);
    check("ldx_pc", {16'h0, pc}, 32'h3);

    // LDY via prefix, then LDX to show the prefix does not linger
    load(8'h10, 8'h8E, 8'hBE, 8'hEF, 8'h8E, 8'h11, 8'h22);
    release_reset();
    push_trace("NPNPNPNPNP"); drain();
    check("ldy_y", {16'h0, y}, 32'hBEEF);
    check("ldy_pc", {16'h0, pc}, 32'h4);
    push_trace("NPNPNP"); drain();
    check("ldx_after_ldy_x", {16'h0, x}, 32'h1122);
    check("ldx_after_ldy_y", {16'h0, y}, 32'hBEEF);
    check("ldx_after_ldy_pc", {16'h0, pc}, 32'h7);

    // Double prefix: second 0x10 acts as NOP, then LDA immediate
    load(8'h10, 8'h10, 8'h86, 8'h33, 8'h12, 8'h12, 8'h12);
    release_reset();
    push_trace("NPNPNPNPNP"); drain();
    check("dbl_prefix_a", {24'h0, a}, 32'h33);
    check("dbl_prefix_pc", {16'h0, pc}, 32'h4);

    // Page-2 opcode other than 0x8E behaves as NOP
    load(8'h10, 8'h86, 8'h12, 8'h12, 8'h12, 8'h12, 8'h12);
    release_reset();
    push_trace("NPNPNP"); drain();
    check("p2_nop_a", {24'h0, a}, 32'h0);
    check("p2_nop_pc", {16'h0, pc}, 32'h2);
    check("p2_nop_ir", {16'h0, ir}, 32'h86);

    // LDA direct
    dp_init = 8'h20;
    load(8'h96, 8'h10, 8'h12, 8'h12, 8'h12, 8'h12, 8'h12);
    mem[16'h2010] = 8'h55;
    release_reset();
    push_trace("NPNPNDNP"); drain();
    check("lda_dir_a", {24'h0, a}, 32'h55);
    check("lda_dir_arl", {24'h0, ar[7:0]}, 32'h10);
    check("lda_dir_pc", {16'h0, pc}, 32'h2);
    dp_init = 8'h00;

    // LDB extended
    load(8'hF6, 8'h12, 8'h34, 8'h12, 8'h12, 8'h12, 8'h12);
    mem[16'h1234] = 8'hAA;
    release_reset();
    push_trace("NPNPNPNRNP"); drain();
    check("ldb_ext_ar", {16'h0, ar}, 32'h1234);
    check("ldb_ext_b", {24'h0, b}, 32'hAA);
    check("ldb_ext_pc", {16'h0, pc}, 32'h3);

    // NOP and an unknown opcode both return to FOP after two cycles
    load(8'h12, 8'h00, 8'h12, 8'h12, 8'h12, 8'h12, 8'h12);
    release_reset();
    push_trace("NPNP"); drain();
    check("nop_ir", {16'h0, ir}, 32'h12);
    check("nop_pc", {16'h0, pc}, 32'h1);
    push_trace("NP"); drain();
    check("unknown_pc", {16'h0, pc}, 32'h2);

    // Reset pulsed during the second read of an extended load
    load(8'hF6, 8'h12, 8'h34, 8'h12, 8'h12, 8'h12, 8'h12);
    mem[16'h1234] = 8'hAA;
    release_reset();
    push_trace("NPNPNP"); drain();
    #1 reset = 1'b0;
    #1;
    check("midrst_mem_read", {28'h0, bus_if.mem_read}, 32'd0);
    check("midrst_fetch", {16'h0, bus_if.fetch}, 32'd0);
    check("midrst_pc_inc", {31'h0, bus_if.pc_inc}, 32'd0);
    release_reset();
    push_trace("NPNPNPNRNP"); drain();
    check("after_rst_b", {24'h0, b}, 32'hAA);
    check("after_rst_pc", {16'h0, pc}, 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
